// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS F stage: PC, variable-latency imem fetch, skid buffer, IF/ID register
//
// Purpose:
//   Owns the PC and the IF/ID pipeline register. Issues one fetch at a time
//   over a req/ack instruction-memory port, parks a completed fetch in a
//   one-entry skid buffer while D is stalled, and applies D-stage redirects
//   after the delay slot has been fetched.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   imem_req     fetch request, held until ack
//   imem_addr    fetch address (= pc)
//   imem_ack     read data valid this cycle
//   imem_rdata   instruction word, sampled on req & ack
//   stall_d      hold IF/ID
//   redirect     D-stage control transfer taken (ignored while stall_d)
//   redirect_pc  redirect target
//   d_instr      IF/ID instruction (0 when invalid)
//   d_pc         IF/ID pc
//   d_valid      IF/ID holds a real instruction
//   d_opcode     d_instr[31:26]
//   d_func       d_instr[5:0]
//   fetch_err    sticky misaligned / out-of-window fetch error

module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter logic [31:0] IM_BASE  = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 4096
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic        d_valid,
  output logic [5:0]  d_opcode,
  output logic [5:0]  d_func,
  output logic        fetch_err
);

  localparam logic [31:0] WIN_BYTES = 32'(IM_WORDS * 4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] dpc_q, dpc_d;
  logic        dvalid_q, dvalid_d;
  // The skid buffer is occupied exactly while in S_HOLD, so it needs no valid bit.
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic [31:0] redir_q, redir_d;
  logic        redir_pend_q, redir_pend_d;
  logic        err_q, err_d;

  logic        take_redir;
  logic [31:0] npc;
  logic [31:0] hold_pc;

  function automatic logic pc_legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a >= IM_BASE) && ((a - IM_BASE) < WIN_BYTES);
  endfunction

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    dpc_d        = dpc_q;
    dvalid_d     = dvalid_q;
    skid_instr_d = skid_instr_q;
    skid_pc_d    = skid_pc_q;
    redir_d      = redir_q;
    redir_pend_d = redir_pend_q;

    take_redir = redirect && !stall_d;
    if (take_redir) begin
      npc = redirect_pc;
    end else if (redir_pend_q) begin
      npc = redir_q;
    end else begin
      npc = pc_q + 32'd4;
    end
    // In HOLD the delay slot is already parked in the skid buffer, so a
    // redirect on the release cycle must replace the pc directly; otherwise
    // the sequential pc after the slot would be fetched before the target.
    hold_pc = take_redir ? redirect_pc : pc_q;

    case (state_q)
      S_IDLE: begin
        state_d = pc_legal(pc_q) ? S_REQ : S_ERR;
      end
      S_REQ: begin
        if (imem_ack) begin
          pc_d         = npc;
          redir_pend_d = 1'b0;
          if (!stall_d) begin
            instr_d  = imem_rdata;
            dpc_d    = pc_q;
            dvalid_d = 1'b1;
            state_d  = pc_legal(npc) ? S_REQ : S_ERR;
          end else begin
            skid_instr_d = imem_rdata;
            skid_pc_d    = pc_q;
            state_d      = S_HOLD;
          end
        end else begin
          if (!stall_d) begin
            instr_d  = 32'd0;
            dvalid_d = 1'b0;
          end
          if (take_redir) begin
            redir_d      = redirect_pc;
            redir_pend_d = 1'b1;
          end
        end
      end
      S_HOLD: begin
        if (!stall_d) begin
          instr_d      = skid_instr_q;
          dpc_d        = skid_pc_q;
          dvalid_d     = 1'b1;
          pc_d         = hold_pc;
          redir_pend_d = 1'b0;
          state_d      = pc_legal(hold_pc) ? S_REQ : S_ERR;
        end
      end
      S_ERR: begin
        if (!stall_d) begin
          instr_d  = 32'd0;
          dvalid_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    err_d = err_q || (state_d == S_ERR);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_RESET;
      instr_q      <= 32'd0;
      dpc_q        <= PC_RESET;
      dvalid_q     <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc_q    <= 32'd0;
      redir_q      <= 32'd0;
      redir_pend_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      dpc_q        <= dpc_d;
      dvalid_q     <= dvalid_d;
      skid_instr_q <= skid_instr_d;
      skid_pc_q    <= skid_pc_d;
      redir_q      <= redir_d;
      redir_pend_q <= redir_pend_d;
      err_q        <= err_d;
    end
  end

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign d_instr   = instr_q;
  assign d_pc      = dpc_q;
  assign d_valid   = dvalid_q;
  assign d_opcode  = instr_q[31:26];
  assign d_func    = instr_q[5:0];
  assign fetch_err = err_q;

endmodule
